// File: rtl/ld_st_rg_pkg.sv
// rtl/ld_st_rg_pkg.sv - shared mode encodings and FSM states for the universal shift register
package ld_st_rg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True for the modes that move bits and produce a serial output bit.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/ld_st_rg_step.sv
// rtl/ld_st_rg_step.sv - one combinational shift/rotate step shared by single-step and multi-cycle paths
module ld_st_rg_step
  import ld_st_rg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  // Next register value and outgoing bit for one step of the selected mode
  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (mode)
      MODE_SHL: begin
        q_next  = {q[WIDTH-2:0], ser_in};
        out_bit = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next  = {ser_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ROTL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      MODE_ROTR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ld_st_rg_universal.sv
// rtl/ld_st_rg_universal.sv - WIDTH-bit load/store/shift register with multi-cycle shift-by-N
module ld_st_rg_universal
  import ld_st_rg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             set,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;
  logic             start_ok;

  // While shifting the latched mode drives the step unit; otherwise the live mode does
  assign step_mode = (state_q == ST_SHIFT) ? mode_q : mode;

  ld_st_rg_step #(.WIDTH(WIDTH)) u_step (
    .q      (q_q),
    .mode   (step_mode),
    .ser_in (ser_in),
    .q_next (step_q),
    .out_bit(step_bit)
  );

  // A start only counts for moving modes; other modes treat it as a plain single step
  assign start_ok = start && is_shift_mode(mode);

  // State register: async clear aborts everything
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_q    <= '0;
      ser_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      ser_q  <= ser_d;
      done_q <= done_d;
    end
  end

  // Next-state logic: preset overrides the FSM, counter reaching one ends the shift
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (!set) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok && (amount != '0)) begin
            state_d = ST_SHIFT;
            cnt_d   = amount;
            mode_d  = mode;
          end
        end
        ST_SHIFT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: register value, serial bit and the completion pulse
  always_comb begin
    q_d    = q_q;
    ser_d  = ser_q;
    done_d = 1'b0;
    if (!set) begin
      q_d = '1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            // zero-length shift completes at once without touching q
            done_d = (amount == '0);
          end else if (mode == MODE_LOAD) begin
            q_d = d_in;
          end else if (is_shift_mode(mode)) begin
            q_d   = step_q;
            ser_d = step_bit;
          end
        end
        ST_SHIFT: begin
          q_d    = step_q;
          ser_d  = step_bit;
          done_d = (cnt_q == CNT_W'(1));
        end
        default: ;
      endcase
    end
  end

  assign q_out   = q_q;
  assign ser_out = ser_q;
  assign busy    = (state_q == ST_SHIFT);
  assign done    = done_q;

endmodule

// File: tb/tb_ld_st_rg_universal.sv
// tb/tb_ld_st_rg_universal.sv - directed table-driven bench for ld_st_rg_universal
module tb_ld_st_rg_universal;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             clr;
  logic             set;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d_in;
  logic             ser_in;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q_out;
  logic             ser_out;
  logic             busy;
  logic             done;

  int checks;
  int failures;

  typedef struct {
    logic       set_n;
    logic [2:0] mode;
    logic [7:0] d;
    logic       si;
    logic       st;
    logic [3:0] amt;
    logic [7:0] eq;
    logic       es;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  ld_st_rg_universal #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .clr    (clr),
    .set    (set),
    .mode   (mode),
    .d_in   (d_in),
    .ser_in (ser_in),
    .start  (start),
    .amount (amount),
    .q_out  (q_out),
    .ser_out(ser_out),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] m, input logic [7:0] d,
                       input logic si, input logic st, input logic [3:0] a);
    set = s; mode = m; d_in = d; ser_in = si; start = st; amount = a;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic s, logic [2:0] m, logic [7:0] d, logic si, logic st,
                              logic [3:0] a, logic [7:0] eq, logic es, logic eb, logic ed);
    vec_t v;
    v.set_n = s; v.mode = m; v.d = d; v.si = si; v.st = st; v.amt = a;
    v.eq = eq; v.es = es; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  initial begin
    int n;
    int seen;
    checks = 0;
    failures = 0;

    //        set mode    d     si st amt   q     ser busy done
    vecs.push_back(mk(1, 3'b001, 8'hA5, 0, 0, 4'd0, 8'hA5, 0, 0, 0)); // load
    vecs.push_back(mk(1, 3'b100, 8'h00, 0, 1, 4'd3, 8'hA5, 0, 1, 0)); // start rotl x3
    vecs.push_back(mk(1, 3'b000, 8'h00, 0, 0, 4'd0, 8'h4B, 1, 1, 0));
    vecs.push_back(mk(1, 3'b000, 8'h00, 0, 0, 4'd0, 8'h96, 0, 1, 0));
    vecs.push_back(mk(1, 3'b000, 8'h00, 0, 0, 4'd0, 8'h2D, 1, 0, 1));
    vecs.push_back(mk(1, 3'b000, 8'h00, 0, 0, 4'd0, 8'h2D, 1, 0, 0)); // done is one cycle
    vecs.push_back(mk(1, 3'b001, 8'h90, 0, 0, 4'd0, 8'h90, 1, 0, 0)); // load keeps ser_out
    vecs.push_back(mk(1, 3'b110, 8'h00, 0, 1, 4'd2, 8'h90, 1, 1, 0)); // start asr x2
    vecs.push_back(mk(1, 3'b001, 8'h55, 1, 1, 4'd9, 8'hC8, 0, 1, 0)); // inputs ignored
    vecs.push_back(mk(1, 3'b000, 8'h00, 0, 0, 4'd0, 8'hE4, 0, 0, 1));
    vecs.push_back(mk(1, 3'b001, 8'h81, 0, 0, 4'd0, 8'h81, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 8'h00, 1, 0, 4'd0, 8'h03, 1, 0, 0)); // single shl
    vecs.push_back(mk(1, 3'b011, 8'h00, 0, 0, 4'd0, 8'h01, 1, 0, 0)); // single shr
    vecs.push_back(mk(1, 3'b111, 8'h00, 1, 1, 4'd3, 8'h01, 1, 0, 0)); // reserved: hold, start ignored
    vecs.push_back(mk(1, 3'b101, 8'h00, 0, 1, 4'd0, 8'h01, 1, 0, 1)); // amount=0
    vecs.push_back(mk(1, 3'b011, 8'h00, 1, 1, 4'd2, 8'h01, 1, 1, 0)); // back-to-back start
    vecs.push_back(mk(1, 3'b000, 8'h00, 1, 1, 4'd7, 8'h80, 1, 1, 0)); // shr samples ser_in=1
    vecs.push_back(mk(1, 3'b000, 8'h00, 0, 0, 4'd0, 8'h40, 0, 0, 1)); // shr samples ser_in=0

    // reset state
    clr = 1'b0;
    drive(1, 3'b000, 8'h00, 0, 0, 4'd0);
    #12;
    chk("reset_q", q_out, 8'h00);
    chk("reset_ser", ser_out, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    @(negedge clk);
    clr = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].set_n, vecs[i].mode, vecs[i].d, vecs[i].si, vecs[i].st, vecs[i].amt);
      edge1();
      chk($sformatf("vec%0d_q", i), q_out, vecs[i].eq);
      chk($sformatf("vec%0d_ser", i), ser_out, vecs[i].es);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].eb);
      chk($sformatf("vec%0d_done", i), done, vecs[i].ed);
    end

    // amount > WIDTH, accepted on the done cycle: 9 rotl steps from 0x40 -> 0x80, last bit out 0
    drive(1, 3'b100, 8'h00, 0, 1, 4'd9);
    edge1();
    drive(1, 3'b000, 8'h00, 0, 0, 4'd0);
    n = 0;
    seen = 0;
    for (int g = 0; g < 40; g++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) n++;
      edge1();
    end
    chk("long_done_seen", seen, 1);
    chk("long_busy_cycles", n, 9);
    chk("long_q", q_out, 8'h80);
    chk("long_ser", ser_out, 1'b0);

    // preset mid-shift: rotr x5 from 0x0F, abort after 2 steps
    drive(1, 3'b001, 8'h0F, 0, 0, 4'd0);
    edge1();
    drive(1, 3'b101, 8'h00, 0, 1, 4'd5);
    edge1();
    drive(1, 3'b000, 8'h00, 0, 0, 4'd0);
    edge1();
    edge1();
    chk("pre_set_q", q_out, 8'hC3);
    chk("pre_set_busy", busy, 1'b1);
    drive(0, 3'b000, 8'h00, 0, 0, 4'd0);
    edge1();
    chk("set_q", q_out, 8'hFF);
    chk("set_busy", busy, 1'b0);
    chk("set_done", done, 1'b0);
    chk("set_ser_kept", ser_out, 1'b1);
    drive(1, 3'b000, 8'h00, 0, 0, 4'd0);
    edge1();
    chk("after_set_done", done, 1'b0);
    chk("after_set_q", q_out, 8'hFF);

    // async clear between edges mid-shift
    drive(1, 3'b001, 8'h3C, 0, 0, 4'd0);
    edge1();
    drive(1, 3'b100, 8'h00, 0, 1, 4'd5);
    edge1();
    drive(1, 3'b000, 8'h00, 0, 0, 4'd0);
    edge1();
    chk("pre_clr_q", q_out, 8'h78);
    #1;
    clr = 1'b0;
    #1;
    chk("clr_q", q_out, 8'h00);
    chk("clr_busy", busy, 1'b0);
    chk("clr_done", done, 1'b0);
    chk("clr_ser", ser_out, 1'b0);
    #1;
    clr = 1'b1;
    edge1();
    chk("after_clr_q", q_out, 8'h00);
    chk("after_clr_busy", busy, 1'b0);
    chk("after_clr_done", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
